// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, BAUD_DIV clocks per bit.
// Ports: clk, reset, rx, rx_ack in; rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy out.
module uart_rx #(
  parameter int BAUD_DIV    = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bitn;
  logic [7:0]             r_shreg;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_ovr;

  logic w_rx_s;
  logic w_cnt_clr;
  logic w_shift;
  logic w_stop_ok;
  logic w_stop_bad;
  logic w_load;

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  // Synchroniser presets to idle-high so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (reset) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_shift    = 1'b0;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_next    = S_START;
          w_cnt_clr = 1'b1;
        end
      end
      S_START: begin
        // Mid-start check: a line back high here was a glitch.
        if (r_cnt == HALF) begin
          w_cnt_clr = 1'b1;
          w_next    = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bitn == 3'd7) w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_clr = 1'b1;
          if (w_rx_s) begin
            w_stop_ok = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_stop_bad = 1'b1;
            w_next     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (w_rx_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A same-edge ack frees the hold register for the new byte.
  assign w_load = w_stop_ok && (!r_valid || rx_ack);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_cnt_clr || r_state == S_IDLE || r_state == S_BREAK)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;

      if (r_state == S_START) r_bitn <= '0;
      else if (w_shift)       r_bitn <= r_bitn + 1'b1;

      if (w_shift) r_shreg <= {w_rx_s, r_shreg[7:1]};

      r_ferr <= w_stop_bad;
      r_ovr  <= w_stop_ok && r_valid && !rx_ack;

      if (w_load) begin
        r_data  <= r_shreg;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_ferr;
  assign rx_overrun   = r_ovr;
  assign rx_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with an event-queue model of uart_rx.
// Model predicts deliver/overrun/frame-error events and their timing.
module tb_uart_rx;

  localparam int BD  = 12;
  localparam int SS  = 2;
  localparam int LAT = (19 * BD) / 2 + SS + 1;

  localparam logic [1:0] K_D = 2'd0;
  localparam logic [1:0] K_O = 2'd1;
  localparam logic [1:0] K_F = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       ack_auto = 1'b0;
  logic       ack_man = 1'b0;
  logic       auto_ack = 1'b0;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int   cyc = 0;
  int   n_ferr = 0;
  int   n_ovr = 0;
  int   m_err = 0;
  int   m_chk = 0;
  int   l_err = 0;
  int   l_chk = 0;
  int   errors;
  int   checks;
  exp_t q[$];

  assign rx_ack = ack_auto | ack_man;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.BAUD_DIV(BD), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun),
    .rx_busy     (rx_busy)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    l_chk++;
    if (got !== want) begin
      l_err++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    ack_man = 1'b1;
    @(posedge clk);
    #1;
    ack_man = 1'b0;
  endtask

  // Called at posedge+1; the start edge is this cycle.
  task automatic send(input logic [7:0] b, input logic stop,
                      input int stop_clks, input logic [1:0] kind);
    exp_t e;
    rx = 1'b0;
    e.kind = kind;
    e.data = b;
    e.due  = cyc + LAT;
    q.push_back(e);
    repeat (BD) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (stop_clks) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && rx_valid) begin
        @(posedge clk);
        @(posedge clk);
        #1;
        ack_auto = 1'b1;
        @(posedge clk);
        #1;
        ack_auto = 1'b0;
      end
    end
  end

  initial begin
    logic       pv;
    logic [7:0] pd;
    logic       ld;
    logic [1:0] k;
    int         n;
    exp_t       e;
    pv = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ld = rx_valid && (!pv || rx_data != pd);
        n  = int'(ld) + int'(rx_frame_err) + int'(rx_overrun);
        if (rx_frame_err) n_ferr++;
        if (rx_overrun)   n_ovr++;
        if (n > 1) begin
          m_chk++;
          m_err++;
          $display("FAIL excl: cyc=%0d load=%0d ferr=%0d ovr=%0d want one",
                   cyc, ld, rx_frame_err, rx_overrun);
        end else if (n == 1) begin
          m_chk++;
          k = ld ? K_D : (rx_frame_err ? K_F : K_O);
          if (q.size() == 0) begin
            m_err++;
            $display("FAIL unexpected: cyc=%0d kind=%0d data=%0h want none",
                     cyc, k, rx_data);
          end else begin
            e = q.pop_front();
            if (k != e.kind || (ld && rx_data != e.data) ||
                cyc < e.due - 1 || cyc > e.due + 1)
              begin
                m_err++;
                $display("FAIL event: got kind=%0d data=%0h cyc=%0d want kind=%0d data=%0h cyc=%0d",
                         k, rx_data, cyc, e.kind, e.data, e.due);
              end
          end
        end else if (q.size() > 0 && cyc > q[0].due + 1) begin
          m_chk++;
          m_err++;
          $display("FAIL timeout: no event by cyc=%0d want kind=%0d data=%0h at %0d",
                   cyc, q[0].kind, q[0].data, q[0].due);
          void'(q.pop_front());
        end
      end
      pv = rx_valid;
      pd = rx_data;
    end
  end

  initial begin
    logic [7:0] b6;
    b6 = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, rx_valid}, 0);
    chk("rst_data", {24'd0, rx_data}, 0);
    chk("rst_busy", {31'd0, rx_busy}, 0);
    chk("rst_pulses", {30'd0, rx_frame_err, rx_overrun}, 0);
    reset = 1'b0;
    idle(5);

    send(8'hA5, 1'b1, BD, K_D);
    idle(4);
    chk("t1_data", {24'd0, rx_data}, 32'hA5);
    chk("t1_valid", {31'd0, rx_valid}, 1);
    ack_pulse();
    chk("t1_ack", {31'd0, rx_valid}, 0);
    ack_pulse();
    chk("t1_ack_idle", {31'd0, rx_valid}, 0);

    auto_ack = 1'b1;
    send(8'h00, 1'b1, BD + 1, K_D);
    send(8'hFF, 1'b1, BD + 1, K_D);
    send(8'h55, 1'b1, BD + 1, K_D);
    send(8'h80, 1'b1, BD, K_D);
    idle(8);
    chk("t2_ovr", n_ovr, 0);
    chk("t2_data", {24'd0, rx_data}, 32'h80);
    chk("t2_valid", {31'd0, rx_valid}, 0);
    auto_ack = 1'b0;

    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_busy_hi", {31'd0, rx_busy}, 1);
    rx = 1'b1;
    repeat (BD) @(posedge clk);
    #1;
    chk("t3_busy_lo", {31'd0, rx_busy}, 0);
    chk("t3_no_valid", {31'd0, rx_valid}, 0);
    send(8'h3C, 1'b1, BD, K_D);
    idle(4);
    chk("t3_data", {24'd0, rx_data}, 32'h3C);
    ack_pulse();

    send(8'h5A, 1'b0, BD, K_F);
    repeat (40) @(posedge clk);
    #1;
    chk("t4_ferr", n_ferr, 1);
    chk("t4_valid", {31'd0, rx_valid}, 0);
    chk("t4_busy", {31'd0, rx_busy}, 1);
    idle(SS + 3);
    chk("t4_busy_lo", {31'd0, rx_busy}, 0);
    chk("t4_ferr_once", n_ferr, 1);
    send(8'h11, 1'b1, BD, K_D);
    idle(4);
    chk("t4_data", {24'd0, rx_data}, 32'h11);
    ack_pulse();

    send(8'h12, 1'b1, BD, K_D);
    idle(4);
    send(8'h34, 1'b1, BD, K_O);
    idle(4);
    chk("t5_data", {24'd0, rx_data}, 32'h12);
    chk("t5_ovr", n_ovr, 1);
    chk("t5_valid", {31'd0, rx_valid}, 1);
    fork
      send(8'h56, 1'b1, BD, K_D);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1;
        ack_man = 1'b1;
        @(posedge clk);
        #1;
        ack_man = 1'b0;
      end
    join
    idle(4);
    chk("t5b_data", {24'd0, rx_data}, 32'h56);
    chk("t5b_valid", {31'd0, rx_valid}, 1);
    chk("t5b_ovr", n_ovr, 1);

    rx = 1'b0;
    repeat (BD) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx = b6[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    rx = b6[4];
    repeat (BD / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t6_valid", {31'd0, rx_valid}, 0);
    chk("t6_data", {24'd0, rx_data}, 0);
    chk("t6_busy", {31'd0, rx_busy}, 0);
    idle(2 * BD);
    send(8'h99, 1'b1, BD, K_D);
    idle(4);
    chk("t6_next", {24'd0, rx_data}, 32'h99);
    chk("t6_next_valid", {31'd0, rx_valid}, 1);
    idle(LAT);
    chk("q_empty", q.size(), 0);

    errors = l_err + m_err;
    checks = l_chk + m_chk;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
